// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename state (busy bit + ROB tag).
// Supplies issue-stage operands combinationally, records issue mappings, retires commits.
module rename_regfile #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int RIDX_W = 5,
  parameter int ROB_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic              issue_rd_en,
  input  logic [RIDX_W-1:0] issue_rd,
  input  logic [ROB_W-1:0]  issue_tag,
  input  logic              rs1_en,
  input  logic              rs2_en,
  input  logic [RIDX_W-1:0] rs1,
  input  logic [RIDX_W-1:0] rs2,
  output logic              q1_busy,
  output logic              q2_busy,
  output logic [ROB_W-1:0]  q1_tag,
  output logic [ROB_W-1:0]  q2_tag,
  output logic [XLEN-1:0]   v1,
  output logic [XLEN-1:0]   v2,
  input  logic              commit_valid,
  input  logic              commit_rd_en,
  input  logic [RIDX_W-1:0] commit_rd,
  input  logic [ROB_W-1:0]  commit_tag,
  input  logic [XLEN-1:0]   commit_data,
  output logic [NREG-1:0]   busy_vec
);

  logic [XLEN-1:0]   value_r [NREG];
  logic [ROB_W-1:0]  tag_r   [NREG];
  logic [NREG-1:0]   busy_r;

  logic              commit_byp_s;
  logic              commit_we_s;
  logic              issue_we_s;
  logic [NREG-1:0]   commit_hit_s;
  logic [NREG-1:0]   issue_hit_s;

  logic              src_en_s   [2];
  logic [RIDX_W-1:0] src_idx_s  [2];
  logic              q_busy_s   [2];
  logic [ROB_W-1:0]  q_tag_s    [2];
  logic [XLEN-1:0]   v_s        [2];

  // Write enables and one-hot register decode for commit and issue
  always_comb begin
    commit_byp_s = commit_valid & commit_rd_en & rdy;
    commit_we_s  = commit_byp_s & (commit_rd != {RIDX_W{1'b0}});
    issue_we_s   = rdy & issue_valid & issue_rd_en & ~flush & (issue_rd != {RIDX_W{1'b0}});
    commit_hit_s = {NREG{1'b0}};
    issue_hit_s  = {NREG{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      commit_hit_s[i] = commit_we_s & (commit_rd == RIDX_W'(i));
      issue_hit_s[i]  = issue_we_s  & (issue_rd  == RIDX_W'(i));
    end
  end

  // Register state; issue beats a same-cycle commit for busy/tag, flush beats both
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= {NREG{1'b0}};
      for (int i = 0; i < NREG; i++) begin
        value_r[i] <= {XLEN{1'b0}};
        tag_r[i]   <= {ROB_W{1'b0}};
      end
    end else if (rdy) begin
      for (int i = 0; i < NREG; i++) begin
        if (commit_hit_s[i]) begin
          value_r[i] <= commit_data;
        end else begin
          value_r[i] <= value_r[i];
        end
        if (flush) begin
          busy_r[i] <= 1'b0;
          tag_r[i]  <= {ROB_W{1'b0}};
        end else if (issue_hit_s[i]) begin
          busy_r[i] <= 1'b1;
          tag_r[i]  <= issue_tag;
        end else if (commit_hit_s[i] && (tag_r[i] == commit_tag)) begin
          busy_r[i] <= 1'b0;
          tag_r[i]  <= tag_r[i];
        end else begin
          busy_r[i] <= busy_r[i];
          tag_r[i]  <= tag_r[i];
        end
      end
    end else begin
      busy_r <= busy_r;
    end
  end

  // Gather both source ports so one loop serves them
  always_comb begin
    src_en_s[0]  = rs1_en;
    src_en_s[1]  = rs2_en;
    src_idx_s[0] = rs1;
    src_idx_s[1] = rs2;
  end

  // Operand read against pre-edge state, with bypass from a matching commit
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      q_busy_s[p] = 1'b0;
      q_tag_s[p]  = {ROB_W{1'b0}};
      v_s[p]      = {XLEN{1'b0}};
      if (!src_en_s[p] || (src_idx_s[p] == {RIDX_W{1'b0}})) begin
        v_s[p] = {XLEN{1'b0}};
      end else if (!busy_r[src_idx_s[p]]) begin
        v_s[p] = value_r[src_idx_s[p]];
      end else if (commit_byp_s && (commit_rd == src_idx_s[p]) &&
                   (commit_tag == tag_r[src_idx_s[p]])) begin
        v_s[p] = commit_data;
      end else begin
        q_busy_s[p] = 1'b1;
        q_tag_s[p]  = tag_r[src_idx_s[p]];
      end
    end
  end

  assign q1_busy  = q_busy_s[0];
  assign q2_busy  = q_busy_s[1];
  assign q1_tag   = q_tag_s[0];
  assign q2_tag   = q_tag_s[1];
  assign v1       = v_s[0];
  assign v2       = v_s[1];
  assign busy_vec = busy_r;

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile with hand-computed expected values.
module tb_rename_regfile;
  localparam int XLEN = 32, NREG = 32, RIDX_W = 5, ROB_W = 4;

  logic              clk = 1'b0;
  logic              rst, rdy, flush;
  logic              issue_valid, issue_rd_en;
  logic [RIDX_W-1:0] issue_rd;
  logic [ROB_W-1:0]  issue_tag;
  logic              rs1_en, rs2_en;
  logic [RIDX_W-1:0] rs1, rs2;
  logic              q1_busy, q2_busy;
  logic [ROB_W-1:0]  q1_tag, q2_tag;
  logic [XLEN-1:0]   v1, v2;
  logic              commit_valid, commit_rd_en;
  logic [RIDX_W-1:0] commit_rd;
  logic [ROB_W-1:0]  commit_tag;
  logic [XLEN-1:0]   commit_data;
  logic [NREG-1:0]   busy_vec;

  int checks_cnt = 0;
  int errors_cnt = 0;

  rename_regfile #(.XLEN(XLEN), .NREG(NREG), .RIDX_W(RIDX_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .issue_valid(issue_valid), .issue_rd_en(issue_rd_en), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .rs1_en(rs1_en), .rs2_en(rs2_en), .rs1(rs1), .rs2(rs2),
    .q1_busy(q1_busy), .q2_busy(q2_busy), .q1_tag(q1_tag), .q2_tag(q2_tag), .v1(v1), .v2(v2),
    .commit_valid(commit_valid), .commit_rd_en(commit_rd_en), .commit_rd(commit_rd),
    .commit_tag(commit_tag), .commit_data(commit_data), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0;
    issue_valid = 1'b0; issue_rd_en = 1'b0; issue_rd = 5'd0; issue_tag = 4'd0;
    commit_valid = 1'b0; commit_rd_en = 1'b0; commit_rd = 5'd0; commit_tag = 4'd0;
    commit_data = 32'd0;
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [RIDX_W-1:0] rd, input logic [ROB_W-1:0] tg);
    issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = rd; issue_tag = tg;
  endtask

  task automatic set_commit(input logic [RIDX_W-1:0] rd, input logic [ROB_W-1:0] tg,
                            input logic [XLEN-1:0] d);
    commit_valid = 1'b1; commit_rd_en = 1'b1; commit_rd = rd; commit_tag = tg; commit_data = d;
  endtask

  task automatic read(input logic [RIDX_W-1:0] a, input logic [RIDX_W-1:0] b);
    rs1_en = 1'b1; rs2_en = 1'b1; rs1 = a; rs2 = b;
    #1;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; idle();
    rs1_en = 1'b1; rs2_en = 1'b1; rs1 = 5'd5; rs2 = 5'd7;
    // Issue held during reset must be ignored
    set_issue(5'd5, 4'd3);
    #1;
    check_val("rst_busy_vec", busy_vec, 32'h0);
    tick(); tick();
    check_val("rst_hold_busy_vec", busy_vec, 32'h0);
    idle();
    rst = 1'b1;
    read(5'd5, 5'd7);
    check_val("rst_v1", v1, 32'h0);
    check_val("rst_v2", v2, 32'h0);
    check_val("rst_q1_busy", q1_busy, 1'b0);
    check_val("rst_q2_busy", q2_busy, 1'b0);
    check_val("rst_q1_tag", q1_tag, 4'd0);
    check_val("rst_busy_vec2", busy_vec, 32'h0);

    // Issue rd=3 tag=9
    set_issue(5'd3, 4'd9);
    tick(); idle();
    read(5'd3, 5'd0);
    check_val("iss3_q1_busy", q1_busy, 1'b1);
    check_val("iss3_q1_tag", q1_tag, 4'd9);
    check_val("iss3_v1", v1, 32'h0);
    check_val("iss3_busy_vec", busy_vec, 32'h8);

    // Commit rd=3 tag=9: same-cycle bypass, then array read
    set_commit(5'd3, 4'd9, 32'hDEADBEEF);
    read(5'd3, 5'd0);
    check_val("byp3_v1", v1, 32'hDEADBEEF);
    check_val("byp3_q1_busy", q1_busy, 1'b0);
    check_val("byp3_q1_tag", q1_tag, 4'd0);
    tick(); idle();
    read(5'd3, 5'd0);
    check_val("arr3_v1", v1, 32'hDEADBEEF);
    check_val("arr3_q1_busy", q1_busy, 1'b0);
    check_val("arr3_busy_vec", busy_vec, 32'h0);

    // rd == rs1 reads the older mapping
    set_issue(5'd3, 4'd1);
    read(5'd3, 5'd0);
    check_val("rdrs_v1", v1, 32'hDEADBEEF);
    check_val("rdrs_q1_busy", q1_busy, 1'b0);
    tick(); idle();

    // Stale commit: younger tag 6 keeps r4 busy
    set_issue(5'd4, 4'd2); tick();
    set_issue(5'd4, 4'd6); tick(); idle();
    set_commit(5'd4, 4'd2, 32'h11);
    read(5'd4, 5'd0);
    check_val("stale_byp_q1_busy", q1_busy, 1'b1);
    check_val("stale_byp_v1", v1, 32'h0);
    tick(); idle();
    read(5'd4, 5'd0);
    check_val("stale_q1_busy", q1_busy, 1'b1);
    check_val("stale_q1_tag", q1_tag, 4'd6);

    // Simultaneous issue tag5 and commit of old tag1 on r8
    set_issue(5'd8, 4'd1); tick(); idle();
    set_issue(5'd8, 4'd5);
    set_commit(5'd8, 4'd1, 32'h22);
    read(5'd0, 5'd8);
    check_val("sim_byp_v2", v2, 32'h22);
    check_val("sim_byp_q2_busy", q2_busy, 1'b0);
    tick(); idle();
    read(5'd0, 5'd8);
    check_val("sim_q2_busy", q2_busy, 1'b1);
    check_val("sim_q2_tag", q2_tag, 4'd5);

    // Flush with r1..r10 busy, commit r2, dropped issue to r12
    for (int i = 1; i <= 10; i++) begin
      set_issue(RIDX_W'(i), ROB_W'(i));
      tick();
    end
    idle();
    #1;
    check_val("pre_flush_busy_vec", busy_vec, 32'h7FE);
    flush = 1'b1;
    set_commit(5'd2, 4'd15, 32'h33);
    set_issue(5'd12, 4'd3);
    tick(); idle();
    read(5'd2, 5'd4);
    check_val("flush_busy_vec", busy_vec, 32'h0);
    check_val("flush_v1_r2", v1, 32'h33);
    check_val("flush_v2_r4", v2, 32'h11);
    read(5'd8, 5'd12);
    check_val("flush_v1_r8", v1, 32'h22);
    check_val("flush_q2_busy_r12", q2_busy, 1'b0);
    check_val("flush_q1_tag_r8", q1_tag, 4'd0);

    // Register 0 ignores issue and commit
    set_issue(5'd0, 4'd7);
    set_commit(5'd0, 4'd0, 32'hFF);
    read(5'd0, 5'd0);
    check_val("r0_byp_v1", v1, 32'h0);
    tick(); idle();
    read(5'd0, 5'd0);
    check_val("r0_v1", v1, 32'h0);
    check_val("r0_q1_busy", q1_busy, 1'b0);
    check_val("r0_busy_vec", busy_vec, 32'h0);

    // rdy=0 freezes state, including flush, and blocks bypass
    set_issue(5'd5, 4'd3); tick(); idle();
    rdy = 1'b0;
    flush = 1'b1;
    set_issue(5'd6, 4'd4);
    set_commit(5'd5, 4'd3, 32'h55);
    read(5'd5, 5'd2);
    check_val("nrdy_q1_busy", q1_busy, 1'b1);
    check_val("nrdy_q1_tag", q1_tag, 4'd3);
    check_val("nrdy_v1", v1, 32'h0);
    tick();
    set_commit(5'd2, 4'd0, 32'h44);
    tick(); idle();
    read(5'd5, 5'd2);
    check_val("nrdy_busy_vec", busy_vec, 32'h20);
    check_val("nrdy_v2_r2", v2, 32'h33);
    rdy = 1'b1;
    set_commit(5'd5, 4'd3, 32'h55);
    tick(); idle();
    read(5'd5, 5'd0);
    check_val("rdy_v1_r5", v1, 32'h55);
    check_val("rdy_busy_vec", busy_vec, 32'h0);

    // Asynchronous reset mid-cycle clears values and busy immediately
    set_issue(5'd9, 4'd1); tick(); idle();
    #2;
    rst = 1'b0;
    read(5'd2, 5'd9);
    check_val("arst_busy_vec", busy_vec, 32'h0);
    check_val("arst_v1_r2", v1, 32'h0);
    check_val("arst_q2_busy", q2_busy, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule

// File: doc/rename_regfile.md
# rename_regfile

Parametrised architectural register file with per-register rename status (busy bit and ROB tag) for the out-of-order core. It supplies issue-stage source operands (ready value or producing ROB tag), records new destination mappings at issue, and retires values at commit. Compared with the previous register file it adds the following:

- parametrised width, depth and tag size;
- a same-cycle commit-to-read bypass;
- a full rename rollback on branch mispredict.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREG, 32, number of architectural registers (power of two; register 0 hardwired to zero)
- RIDX_W, 5, register index width, equal to log2(NREG)
- ROB_W, 4, ROB tag width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; when low, state holds and reads stay live
- flush  in  1  mispredict rollback; clears every busy bit
- issue_valid  in  1  an instruction is issuing this cycle
- issue_rd_en  in  1  the issuing instruction writes a destination
- issue_rd  in  RIDX_W  destination register of the issuing instruction
- issue_tag  in  ROB_W  ROB entry allocated to the issuing instruction
- rs1_en, rs2_en  in  1  source operand is used
- rs1, rs2  in  RIDX_W  source register indices
- q1_busy, q2_busy  out  1  the source's value is not yet available
- q1_tag, q2_tag  out  ROB_W  producing ROB tag; 0 when not busy
- v1, v2  out  XLEN  source value; 0 when busy or when the source is unused
- commit_valid  in  1  ROB is retiring an entry this cycle
- commit_rd_en  in  1  the retiring entry writes a register
- commit_rd  in  RIDX_W  destination of the retiring entry
- commit_tag  in  ROB_W  ROB tag of the retiring entry
- commit_data  in  XLEN  result being retired
- busy_vec  out  NREG  busy bit of every register, for debug and the bench

## Operation
State per register: value[XLEN], busy, tag[ROB_W]. Register 0 always reads value 0 and is never busy. Writes to register 0 are ignored.

Read path (combinational), evaluated per source port i:
- If rsi_en=0 or rsi=0: qi_busy=0, qi_tag=0, vi=0.
- Else if busy[rsi]=0: qi_busy=0, vi=value[rsi].
- Else if a commit bypass hits: qi_busy=0, vi=commit_data. A hit requires all of:
  - commit_valid, commit_rd_en and rdy are all 1;
  - commit_rd equals rsi;
  - commit_tag equals tag[rsi].
- Else: qi_busy=1, qi_tag=tag[rsi], vi=0.

Reads always see the mapping as it stood before this cycle's issue write. An instruction with rd equal to rs1 therefore reads the older producer.

Write path, applied on the rising edge only when rdy=1:
- Commit (commit_valid, commit_rd_en, commit_rd≠0):
  - value[commit_rd] takes commit_data unconditionally.
  - busy[commit_rd] clears only if tag[commit_rd] equals commit_tag. Otherwise a younger writer still owns the register and busy stays set.
- Issue (issue_valid, issue_rd_en, issue_rd≠0, flush=0): busy[issue_rd] is set to 1 and tag[issue_rd] takes issue_tag.
- Same register targeted by both issue and commit in one cycle: the value is written, and the issue mapping wins for both busy and tag.
- flush=1: every busy bit clears and every tag is set to 0. Issue is ignored that cycle. Commit still writes its value, because the retiring entry is older than the mispredict. Values are otherwise retained.

With rdy=0, no state changes, including on flush. Outputs still follow the inputs.

## Timing
- Reads are zero-latency (combinational). Issue and commit updates become visible on the cycle after the edge.
- Reset assertion immediately clears all values, busy bits and tags to 0. This overrides any in-flight issue, commit or flush.
- Values of every output during and right after reset:
  - q1_busy, q2_busy = 0
  - q1_tag, q2_tag = 0
  - v1, v2 = 0
  - busy_vec = 0
- Release of reset is synchronous to clk. The first update happens on the first rising edge after rst goes high.
- One issue and one commit are accepted per cycle. No backpressure; the ROB guarantees tag uniqueness.

## Test plan
- Reset then read: rst low, then high, with rs1=5, rs2=7 -> v1=0, v2=0, q1_busy=0, q2_busy=0, busy_vec=0.
- Issue then commit:
  - Issue rd=3, tag=9 -> next cycle, rs1=3 gives q1_busy=1, q1_tag=9.
  - Commit rd=3, tag=9, data=0xDEADBEEF -> the same cycle bypasses v1=0xDEADBEEF with q1_busy=0; the next cycle reads from the array, still 0xDEADBEEF with q1_busy=0.
- Stale commit:
  - Issue rd=4 tag=2, then issue rd=4 tag=6.
  - Commit rd=4, tag=2, data=0x11 -> value[4]=0x11, but rs1=4 still gives q1_busy=1, q1_tag=6.
- Simultaneous issue and commit on rd=8 (issue tag=5, commit of the old tag 1 with data=0x22) -> busy[8]=1, tag[8]=5, value[8]=0x22.
- Flush: with r1 to r10 busy, flush=1 together with commit rd=2 data=0x33 -> busy_vec=0 and value[2]=0x33. An issue in the same cycle to rd=12 is dropped, so busy_vec[12]=0.
- Register 0 and rdy:
  - Issue or commit to rd=0 with data=0xFF -> rs1=0 reads 0 and is not busy.
  - With rdy=0, issue rd=6 -> busy_vec unchanged.
